// File: rtl/result_display_ctrl_if.sv
// Result-word stream between the NPU result source and the display buffer.
interface result_display_ctrl_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  in_valid;
   logic [4*DIGITS-1:0]   in_data;
   logic                  in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/result_display_ctrl.sv
// Buffers NPU result words and shows one entry at a time as hex nibbles.
// Optional feature macro: AUTO_SCROLL_EN (timer-driven advance every HOLD_CYCLES).
module result_display_ctrl #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned HOLD_CYCLES = 50_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   result_display_ctrl_if.slave       res,
   input  logic                       step,
   input  logic                       clear,
   output logic [4*DIGITS-1:0]        nibbles,
   output logic [DIGITS-1:0]          digit_blank,
   output logic [$clog2(DEPTH)-1:0]   index,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int unsigned DATA_W = 4 * DIGITS;
   localparam int unsigned IW     = $clog2(DEPTH);
   localparam int unsigned CW     = IW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLD_CYCLES < 2) begin : g_bad_param
      $error("result_display_ctrl: DEPTH must be a power of 2 >= 2 and HOLD_CYCLES >= 2");
   end

   typedef enum logic {EMPTY, SHOW} state_t;

   state_t              state, state_n;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   nibbles_n;
   logic [DIGITS-1:0]   blank_n;
   logic [IW-1:0]       index_n, idx_next;
   logic [CW-1:0]       count_n;
   logic                wr, expire, adv;

   assign res.in_ready = (count < CW'(DEPTH)) && !clear;
   assign wr           = res.in_valid && res.in_ready;

`ifdef AUTO_SCROLL_EN
   localparam int unsigned TW = $clog2(HOLD_CYCLES);
   logic [TW-1:0] timer, timer_n;
   assign expire = (state == SHOW) && (timer == TW'(HOLD_CYCLES - 1));
`else
   assign expire = 1'b0;
`endif

   // A step coinciding with timer expiry yields a single advance.
   assign adv      = (state == SHOW) && !clear && (step || expire);
   // Wrap against the count held before any write in this same cycle.
   assign idx_next = ({1'b0, index} == count - CW'(1)) ? '0 : index + IW'(1);

   always_comb begin
      state_n   = state;
      count_n   = count;
      index_n   = index;
      nibbles_n = nibbles;
      blank_n   = digit_blank;
`ifdef AUTO_SCROLL_EN
      timer_n   = timer;
`endif
      if (clear) begin
         state_n   = EMPTY;
         count_n   = '0;
         index_n   = '0;
         nibbles_n = '0;
         blank_n   = '1;
`ifdef AUTO_SCROLL_EN
         timer_n   = '0;
`endif
      end else begin
         if (wr) count_n = count + CW'(1);
         case (state)
            EMPTY: begin
               if (wr) begin
                  state_n   = SHOW;
                  index_n   = '0;
                  nibbles_n = res.in_data;
                  blank_n   = '0;
               end
            end
            SHOW: begin
               if (adv) begin
                  index_n   = idx_next;
                  nibbles_n = mem[idx_next];
               end
            end
            default: state_n = EMPTY;
         endcase
`ifdef AUTO_SCROLL_EN
         if (state != SHOW || adv) timer_n = '0;
         else                      timer_n = timer + TW'(1);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= EMPTY;
         count       <= '0;
         index       <= '0;
         nibbles     <= '0;
         digit_blank <= '1;
`ifdef AUTO_SCROLL_EN
         timer       <= '0;
`endif
      end else begin
         state       <= state_n;
         count       <= count_n;
         index       <= index_n;
         nibbles     <= nibbles_n;
         digit_blank <= blank_n;
`ifdef AUTO_SCROLL_EN
         timer       <= timer_n;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[count[IW-1:0]] <= res.in_data;
   end
endmodule
